// File: rtl/bip2_run_controller_if.sv
// Host/debug port of the BIP2 run controller: run control, program write request and
// the write-refused pulse returned to the host.
interface bip2_run_controller_if #(
  parameter int OAW = 11,
  parameter int IDW = 16
);
  logic           host_start_in;
  logic           host_stop_in;
  logic           host_wr_in;
  logic [OAW-1:0] host_address_in;
  logic [IDW-1:0] host_data_in;
  logic           wr_reject_out;

  modport master (
    output host_start_in, host_stop_in, host_wr_in, host_address_in, host_data_in,
    input  wr_reject_out
  );

  modport slave (
    input  host_start_in, host_stop_in, host_wr_in, host_address_in, host_data_in,
    output wr_reject_out
  );
endinterface

// File: rtl/bip2_run_controller.sv
// BIP2 run controller: holds the core in reset while the host loads program memory,
// releases it on start, and stops on HLT, host stop or watchdog timeout.
//
//   state  | meaning
//   IDLE   | after reset, core held in reset
//   LOAD   | host is writing the instruction memory, core held in reset
//   ARM    | single cycle: clear count and cause, core still in reset
//   RUN    | core running, cycle count advancing, halt checks active
//   HALTED | core frozen out of reset, count and cause held
module bip2_run_controller #(
  parameter int OPERAND_ADDRESS_WIDTH  = 11,
  parameter int INSTRUCTION_DATA_WIDTH = 16,
  parameter int OPCODE_WIDTH           = 5,
  parameter int CYCLE_COUNT_WIDTH      = 32
) (
  input  logic                              clock_in,
  input  logic                              reset_in,
  bip2_run_controller_if.slave              host,
  input  logic [CYCLE_COUNT_WIDTH-1:0]      timeout_limit_in,
  input  logic [INSTRUCTION_DATA_WIDTH-1:0] instruction_in,
  output logic                              imem_wr_out,
  output logic [OPERAND_ADDRESS_WIDTH-1:0]  imem_address_out,
  output logic [INSTRUCTION_DATA_WIDTH-1:0] imem_data_out,
  output logic                              core_reset_out,
  output logic [2:0]                        state_out,
  output logic [1:0]                        halt_cause_out,
  output logic [CYCLE_COUNT_WIDTH-1:0]      cycle_count_out
);
  localparam int OAW = OPERAND_ADDRESS_WIDTH;
  localparam int IDW = INSTRUCTION_DATA_WIDTH;
  localparam int CCW = CYCLE_COUNT_WIDTH;
  localparam logic [CCW-1:0] CNT_ONE = CCW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOAD   = 3'b001,
    S_ARM    = 3'b010,
    S_RUN    = 3'b011,
    S_HALTED = 3'b100
  } state_t;

  state_t         state_q, state_d;
  logic           core_reset_q, core_reset_d;
  logic           imem_wr_q, imem_wr_d;
  logic [OAW-1:0] imem_address_q, imem_address_d;
  logic [IDW-1:0] imem_data_q, imem_data_d;
  logic [CCW-1:0] cycle_count_q, cycle_count_d;
  logic [1:0]     halt_cause_q, halt_cause_d;
  logic           wr_reject_q, wr_reject_d;

  logic           op_hlt;
  logic           write_ok;
  logic [CCW-1:0] count_inc;
  logic [1:0]     halt_code;

  assign op_hlt    = (instruction_in[IDW-1 -: OPCODE_WIDTH] == '0);
  assign count_inc = cycle_count_q + CNT_ONE;
  assign write_ok  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_HALTED);

  // A saturated count wraps count_inc to zero, which can never equal a non-zero limit.
  always_comb begin
    halt_code = 2'b00;
    if (op_hlt)
      halt_code = 2'b01;
    else if (host.host_stop_in)
      halt_code = 2'b10;
    else if ((timeout_limit_in != '0) && (count_inc == timeout_limit_in))
      halt_code = 2'b11;
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q        <= S_IDLE;
      core_reset_q   <= 1'b0;
      imem_wr_q      <= 1'b0;
      imem_address_q <= '0;
      imem_data_q    <= '0;
      cycle_count_q  <= '0;
      halt_cause_q   <= 2'b00;
      wr_reject_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      core_reset_q   <= core_reset_d;
      imem_wr_q      <= imem_wr_d;
      imem_address_q <= imem_address_d;
      imem_data_q    <= imem_data_d;
      cycle_count_q  <= cycle_count_d;
      halt_cause_q   <= halt_cause_d;
      wr_reject_q    <= wr_reject_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (host.host_start_in)   state_d = S_ARM;
        else if (host.host_wr_in) state_d = S_LOAD;
      end
      S_LOAD:  if (host.host_start_in) state_d = S_ARM;
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (halt_code != 2'b00) state_d = S_HALTED;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with state_out.
  always_comb begin
    imem_wr_d      = host.host_wr_in && write_ok;
    imem_address_d = imem_wr_d ? host.host_address_in : imem_address_q;
    imem_data_d    = imem_wr_d ? host.host_data_in    : imem_data_q;
    wr_reject_d    = host.host_wr_in && !write_ok;
    core_reset_d   = (state_d == S_RUN) || (state_d == S_HALTED);
    cycle_count_d  = cycle_count_q;
    halt_cause_d   = halt_cause_q;
    if (state_d == S_ARM) begin
      cycle_count_d = '0;
      halt_cause_d  = 2'b00;
    end else if (state_q == S_RUN) begin
      cycle_count_d = (&cycle_count_q) ? cycle_count_q : count_inc;
      if (halt_code != 2'b00) halt_cause_d = halt_code;
    end
  end

  assign state_out          = state_q;
  assign core_reset_out     = core_reset_q;
  assign imem_wr_out        = imem_wr_q;
  assign imem_address_out   = imem_address_q;
  assign imem_data_out      = imem_data_q;
  assign cycle_count_out    = cycle_count_q;
  assign halt_cause_out     = halt_cause_q;
  assign host.wr_reject_out = wr_reject_q;
endmodule

// File: tb/tb_bip2_run_controller.sv
// Self-checking bench for bip2_run_controller: directed scenarios plus randomized runs
// whose outcome is predicted from the halt rules by run-cycle index.
module tb_bip2_run_controller;
  logic        clock_in = 1'b0;
  logic        reset_in;
  logic [31:0] timeout_limit_in;
  logic [15:0] instruction_in;
  logic        imem_wr_out;
  logic [10:0] imem_address_out;
  logic [15:0] imem_data_out;
  logic        core_reset_out;
  logic [2:0]  state_out;
  logic [1:0]  halt_cause_out;
  logic [31:0] cycle_count_out;

  bip2_run_controller_if #(.OAW(11), .IDW(16)) host_if ();

  bip2_run_controller dut (
    .clock_in         (clock_in),
    .reset_in         (reset_in),
    .host             (host_if.slave),
    .timeout_limit_in (timeout_limit_in),
    .instruction_in   (instruction_in),
    .imem_wr_out      (imem_wr_out),
    .imem_address_out (imem_address_out),
    .imem_data_out    (imem_data_out),
    .core_reset_out   (core_reset_out),
    .state_out        (state_out),
    .halt_cause_out   (halt_cause_out),
    .cycle_count_out  (cycle_count_out)
  );

  always #5 clock_in = ~clock_in;

  localparam logic [2:0] ST_IDLE = 3'b000, ST_LOAD = 3'b001, ST_ARM = 3'b010,
                         ST_RUN = 3'b011, ST_HALTED = 3'b100;
  localparam logic [15:0] FILLER = 16'h2801;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] prog   [0:63];
  logic [15:0] tb_mem [0:2047];

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host write from IDLE/LOAD/HALTED; leaves host_wr_in asserted for back-to-back use.
  task automatic host_write(input logic [10:0] addr, input logic [15:0] data);
    host_if.host_wr_in      = 1'b1;
    host_if.host_address_in = addr;
    host_if.host_data_in    = data;
    tb_mem[addr]            = data;
    tick();
    chk("wr_en",     32'(imem_wr_out), 32'd1);
    chk("wr_addr",   32'(imem_address_out), 32'(addr));
    chk("wr_data",   32'(imem_data_out), 32'(data));
    chk("wr_state",  32'(state_out), 32'(ST_LOAD));
    chk("wr_noreject", 32'(host_if.wr_reject_out), 32'd0);
  endtask

  // Start a run and follow it cycle by cycle. The expected halt for RUN cycle n follows
  // directly from that cycle's instruction, stop request and limit.
  task automatic do_run(input int stop_at, input logic [31:0] lim, input int budget,
                        input bit rand_wr, input int chg_at, input logic [31:0] chg_lim);
    bit       halted;
    bit       wr_now;
    logic [1:0] cause;
    host_if.host_wr_in    = 1'b0;
    host_if.host_stop_in  = 1'b0;
    timeout_limit_in      = lim;
    host_if.host_start_in = 1'b1;
    tick();
    host_if.host_start_in = 1'b0;
    chk("arm_state", 32'(state_out), 32'(ST_ARM));
    chk("arm_corerst", 32'(core_reset_out), 32'd0);
    tick();
    chk("run_state", 32'(state_out), 32'(ST_RUN));
    chk("run_corerst", 32'(core_reset_out), 32'd1);
    chk("run_count0", cycle_count_out, 32'd0);
    chk("run_cause0", 32'(halt_cause_out), 32'd0);
    halted = 1'b0;
    for (int n = 1; n <= budget && !halted; n++) begin
      instruction_in       = (n <= 64) ? prog[n-1] : FILLER;
      host_if.host_stop_in = (n == stop_at);
      if (n == chg_at) timeout_limit_in = chg_lim;
      wr_now = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      host_if.host_wr_in      = wr_now;
      host_if.host_address_in = 11'($urandom);
      host_if.host_data_in    = 16'($urandom);
      cause = 2'b00;
      if (instruction_in[15:11] == 5'd0)                      cause = 2'b01;
      else if (host_if.host_stop_in)                          cause = 2'b10;
      else if (timeout_limit_in != 0 && n == timeout_limit_in) cause = 2'b11;
      tick();
      host_if.host_wr_in   = 1'b0;
      host_if.host_stop_in = 1'b0;
      chk("run_reject", 32'(host_if.wr_reject_out), 32'(wr_now));
      chk("run_nowr", 32'(imem_wr_out), 32'd0);
      chk("run_count", cycle_count_out, 32'(n));
      if (cause != 2'b00) begin
        chk("halt_state", 32'(state_out), 32'(ST_HALTED));
        chk("halt_cause", 32'(halt_cause_out), 32'(cause));
        chk("halt_corerst", 32'(core_reset_out), 32'd1);
        halted = 1'b1;
      end else begin
        chk("run_hold", 32'(state_out), 32'(ST_RUN));
      end
    end
  endtask

  initial begin
    reset_in                = 1'b0;
    host_if.host_start_in   = 1'b0;
    host_if.host_stop_in    = 1'b0;
    host_if.host_wr_in      = 1'b0;
    host_if.host_address_in = '0;
    host_if.host_data_in    = '0;
    timeout_limit_in        = '0;
    instruction_in          = FILLER;

    repeat (3) tick();
    chk("rst_state",   32'(state_out), 32'(ST_IDLE));
    chk("rst_corerst", 32'(core_reset_out), 32'd0);
    chk("rst_count",   cycle_count_out, 32'd0);
    chk("rst_cause",   32'(halt_cause_out), 32'd0);
    chk("rst_wr",      32'(imem_wr_out), 32'd0);
    chk("rst_reject",  32'(host_if.wr_reject_out), 32'd0);
    reset_in = 1'b1;
    tick();
    chk("idle_hold", 32'(state_out), 32'(ST_IDLE));

    // Program load, back to back
    host_write(11'd0, 16'h1801);
    host_write(11'd1, 16'h2801);
    host_write(11'd2, 16'h0000);
    host_if.host_wr_in = 1'b0;
    tick();
    chk("wr_single", 32'(imem_wr_out), 32'd0);
    chk("load_state", 32'(state_out), 32'(ST_LOAD));

    // Run the loaded program: HLT fetched on the third RUN cycle
    for (int i = 0; i < 64; i++) prog[i] = (i < 3) ? tb_mem[i] : FILLER;
    do_run(0, 32'd0, 10, 1'b0, 0, 32'd0);
    chk("prog_count", cycle_count_out, 32'd3);
    chk("prog_cause", 32'(halt_cause_out), 32'd1);

    // Watchdog at 10, then count frozen in HALTED
    for (int i = 0; i < 64; i++) prog[i] = FILLER;
    do_run(0, 32'd10, 20, 1'b0, 0, 32'd0);
    repeat (3) tick();
    chk("tmo_freeze", cycle_count_out, 32'd10);
    chk("tmo_cause",  32'(halt_cause_out), 32'd3);
    host_if.host_start_in = 1'b1;
    host_if.host_stop_in  = 1'b1;
    tick();
    host_if.host_start_in = 1'b0;
    host_if.host_stop_in  = 1'b0;
    chk("restart_arm", 32'(state_out), 32'(ST_ARM));
    tick();
    tick();
    chk("restart_count1", cycle_count_out, 32'd1);

    // The restart above is ongoing; reset it mid-run
    reset_in = 1'b0;
    tick();
    reset_in = 1'b1;
    chk("midrst_state",   32'(state_out), 32'(ST_IDLE));
    chk("midrst_corerst", 32'(core_reset_out), 32'd0);
    chk("midrst_count",   cycle_count_out, 32'd0);

    // Watchdog disabled: still running after 1000 cycles, then reset out of it
    do_run(0, 32'd0, 1000, 1'b1, 0, 32'd0);
    chk("nolimit_state", 32'(state_out), 32'(ST_RUN));
    reset_in = 1'b0;
    tick();
    reset_in = 1'b1;
    chk("rst2_state", 32'(state_out), 32'(ST_IDLE));
    chk("rst2_cause", 32'(halt_cause_out), 32'd0);

    // HLT outranks a simultaneous host stop
    prog[0] = 16'h0000;
    do_run(1, 32'd0, 5, 1'b1, 0, 32'd0);
    prog[0] = FILLER;
    // Host stop alone, with writes refused during RUN
    do_run(7, 32'd0, 10, 1'b1, 0, 32'd0);
    // Limit lowered below the running count never fires; host stop ends it
    do_run(40, 32'd20, 45, 1'b0, 6, 32'd3);

    // Write from HALTED goes to LOAD and drops core reset
    host_write(11'h7ff, 16'hbeef);
    host_if.host_wr_in = 1'b0;
    chk("halt_wr_corerst", 32'(core_reset_out), 32'd0);

    for (int it = 0; it < 15; it++) begin
      int          hp;
      int          stop;
      logic [31:0] lim;
      logic [15:0] w;
      hp = $urandom_range(0, 63);
      for (int i = 0; i < 64; i++) begin
        w = 16'($urandom);
        if (w[15:11] == 5'd0) w[15:11] = 5'd1;
        prog[i] = w;
      end
      w = prog[hp];
      w[15:11] = 5'd0;
      prog[hp] = w;
      stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 64) : 0;
      lim  = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 70));
      if ($urandom_range(0, 1) == 1) begin
        host_write(11'($urandom), 16'($urandom));
        host_if.host_wr_in = 1'b0;
      end
      do_run(stop, lim, 80, 1'b1, 0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
